// File: rtl/sync_receiver_pkg.sv
// rtl/sync_receiver_pkg.sv - shared FSM encodings and payload width default for sync_receiver
package sync_receiver_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/baud_edge_det.sv
// rtl/baud_edge_det.sv - rising-edge detector turning the baud strobe into a one-cycle tick
//
// Ports:
//   clk_i    : system clock
//   resetn_i : synchronous active-low reset
//   baud_i   : bit-rate strobe, synchronous to clk_i
//   tick_o   : high for the single cycle where baud_i is 1 and its registered copy is 0
module baud_edge_det (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic baud_i,
    output logic tick_o
);

    logic baud_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_i;
        end
    end

    assign tick_o = baud_i & ~baud_q;

endmodule

// File: rtl/sync_receiver.sv
// rtl/sync_receiver.sv - serial frame receiver: start, DATA_W bits LSB first, even parity, stop
//
// Ports:
//   CLK        : system clock, rising edge
//   CLR        : synchronous active-low reset
//   CLK_Baud   : bit-rate strobe; its rising edge is one baud tick
//   Enable     : when low, baud ticks are ignored and the frame state holds
//   IN_ser     : serial line, idle high
//   Ack        : consumer acknowledge of the word in Data_Out
//   Data_Out   : last received payload
//   Valid      : Data_Out holds an unacknowledged word
//   Parity_Err : parity status of the word in Data_Out
//   Frame_Err  : stop-bit status of the word in Data_Out
//   Overrun    : a word was overwritten before it was acknowledged
//   Busy       : a frame is in progress
module sync_receiver
    import sync_receiver_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              CLK_Baud,
    input  logic              Enable,
    input  logic              IN_ser,
    input  logic              Ack,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Valid,
    output logic              Parity_Err,
    output logic              Frame_Err,
    output logic              Overrun,
    output logic              Busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              baud_tick;
    logic              sample_en;

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              overrun_q;

    baud_edge_det u_baud_edge_det (
        .clk_i    (CLK),
        .resetn_i (CLR),
        .baud_i   (CLK_Baud),
        .tick_o   (baud_tick)
    );

    assign sample_en = baud_tick & Enable;

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (Ack && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (sample_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!IN_ser) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q[cnt_q] <= IN_ser;
                        cnt_q          <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_BIT) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= IN_ser;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Delivery is placed after the Ack handling above so a
                        // completing frame overrides a same-cycle acknowledge.
                        state_q   <= ST_IDLE;
                        data_q    <= shift_q;
                        valid_q   <= 1'b1;
                        perr_q    <= (^shift_q) ^ par_q;
                        ferr_q    <= ~IN_ser;
                        overrun_q <= valid_q & ~Ack;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Data_Out   = data_q;
    assign Valid      = valid_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Overrun    = overrun_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sync_receiver.sv
// tb/tb_sync_receiver.sv - self-checking bench for sync_receiver
module tb_sync_receiver;

    logic       clk;
    logic       clr;
    logic       clk_baud;
    logic       enable;
    logic       in_ser;
    logic       ack;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ack_after;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[6];

    sync_receiver #(.DATA_W(8)) dut (
        .CLK        (clk),
        .CLR        (clr),
        .CLK_Baud   (clk_baud),
        .Enable     (enable),
        .IN_ser     (in_ser),
        .Ack        (ack),
        .Data_Out   (data_out),
        .Valid      (valid),
        .Parity_Err (parity_err),
        .Frame_Err  (frame_err),
        .Overrun    (overrun),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One baud period: strobe high for two clocks, low for two. Called at posedge+1.
    task automatic baud_bit(input logic b, input logic en);
        in_ser   = b;
        enable   = en;
        clk_baud = 1'b1;
        repeat (2) @(posedge clk);
        #1 clk_baud = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        baud_bit(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) baud_bit(d[i], 1'b1);
        baud_bit(par, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_head(d, par);
        baud_bit(stop, 1'b1);
        in_ser = 1'b1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;
        clk_baud = 1'b0;
        enable   = 1'b1;
        in_ser   = 1'b1;
        ack      = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        // Idle-high line must not start a frame.
        baud_bit(1'b1, 1'b1);
        check("idle_busy", 32'(busy), 32'h0);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            check($sformatf("v%0d_data", v), 32'(data_out), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_valid", v), 32'(valid), 32'h1);
            check($sformatf("v%0d_perr", v), 32'(parity_err), 32'(vecs[v].exp_perr));
            check($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
            if (vecs[v].ack_after) begin
                pulse_ack();
                check($sformatf("v%0d_ack_valid", v), 32'(valid), 32'h0);
                check($sformatf("v%0d_ack_ovr", v), 32'(overrun), 32'h0);
                check($sformatf("v%0d_ack_hold", v), 32'(data_out), 32'(vecs[v].exp_data));
            end
        end

        // Ack with nothing pending changes nothing.
        pulse_ack();
        check("idle_ack_valid", 32'(valid), 32'h0);
        check("idle_ack_ovr", 32'(overrun), 32'h0);
        check("idle_ack_data", 32'(data_out), 32'hC3);

        // Enable gating mid-frame of 0x81, ignored ticks drive a wrong level.
        baud_bit(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) baud_bit(1'(8'h81 >> i), 1'b1);
        for (int i = 0; i < 3; i++) baud_bit(1'b1, 1'b0);
        check("gate_busy", 32'(busy), 32'h1);
        for (int i = 4; i < 8; i++) baud_bit(1'(8'h81 >> i), 1'b1);
        baud_bit(1'b0, 1'b1);
        // Stop tick by hand to observe the one-cycle latency.
        in_ser   = 1'b1;
        clk_baud = 1'b1;
        check("lat_pre_valid", 32'(valid), 32'h0);
        @(posedge clk);
        #1;
        check("lat_post_valid", 32'(valid), 32'h1);
        check("gate_data", 32'(data_out), 32'h81);
        check("gate_perr", 32'(parity_err), 32'h0);
        check("gate_ferr", 32'(frame_err), 32'h0);
        @(posedge clk);
        #1 clk_baud = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Frame completing in the same cycle as Ack: new word wins, no overrun.
        send_head(8'h22, 1'b0);
        in_ser   = 1'b1;
        clk_baud = 1'b1;
        ack      = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        check("same_data", 32'(data_out), 32'h22);
        check("same_valid", 32'(valid), 32'h1);
        check("same_ovr", 32'(overrun), 32'h0);
        @(posedge clk);
        #1 clk_baud = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after four data bits of a frame while a word is pending.
        baud_bit(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) baud_bit(1'(8'hF0 >> i), 1'b1);
        check("mid_busy", 32'(busy), 32'h1);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_perr", 32'(parity_err), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        check("mid_rst_ovr", 32'(overrun), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        clr = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("post_rst_data", 32'(data_out), 32'h5A);
        check("post_rst_valid", 32'(valid), 32'h1);
        check("post_rst_perr", 32'(parity_err), 32'h0);
        check("post_rst_ferr", 32'(frame_err), 32'h0);
        check("post_rst_ovr", 32'(overrun), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_receiver.md
SYNC_RECEIVER -- requirements
Module: sync_receiver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port CLK  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port CLR  input  1  reset: one clock, synchronous, active-low.
REQ-004 The block SHALL have port CLK_Baud  input  1  bit-rate strobe, synchronous to CLK.
REQ-005 The block SHALL have port Enable  input  1  gates bit sampling.
REQ-006 The block SHALL have port IN_ser  input  1  serial line, idle high.
REQ-007 The block SHALL have port Ack  input  1  consumer acknowledge of the current word.
REQ-008 The block SHALL have port Data_Out  output  DATA_W  last received payload.
REQ-009 The block SHALL have port Valid  output  1  Data_Out holds an unacknowledged word.
REQ-010 The block SHALL have port Parity_Err  output  1  parity status of the word in Data_Out.
REQ-011 The block SHALL have port Frame_Err  output  1  stop-bit status of the word in Data_Out.
REQ-012 The block SHALL have port Overrun  output  1  a word was overwritten before Ack.
REQ-013 The block SHALL have port Busy  output  1  a frame is in progress (state not IDLE).

Function
REQ-014 The frame format SHALL be: start 0, DATA_W data bits LSB first, even-parity bit (XOR of data bits), stop 1.
REQ-015 A baud tick SHALL be the CLK cycle in which CLK_Baud=1 and its one-cycle-registered copy is 0.
REQ-016 IN_ser SHALL be sampled only on baud ticks with Enable=1; ticks with Enable=0 are ignored and the state, bit counter and shift register hold.
REQ-017 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-018 In IDLE, a sample of 0 SHALL move to DATA with bit counter 0; a sample of 1 SHALL stay in IDLE.
REQ-019 In DATA, each sample SHALL be written to shift-register bit [counter] and the counter incremented; the sample at counter DATA_W-1 SHALL move to PARITY.
REQ-020 In PARITY, the sample SHALL be stored as the received parity bit, then the FSM SHALL move to STOP.
REQ-021 In STOP, the sample SHALL complete the frame and the FSM SHALL return to IDLE.
REQ-022 On the CLK cycle after the stop sample, the block SHALL set Data_Out to the shift register, Valid=1, Parity_Err=(XOR of data bits) XOR (parity bit), and Frame_Err=NOT stop sample.
REQ-023 A frame with Frame_Err=1 SHALL still be delivered, and the next start search SHALL begin on the following tick.
REQ-024 Ack=1 while Valid=1 SHALL clear Valid and Overrun on the next cycle.
REQ-025 Ack while Valid=0 SHALL be ignored.
REQ-026 If a frame completes while Valid=1 and Ack=0, the block SHALL overwrite Data_Out and all error flags and set Overrun=1.
REQ-027 If Ack=1 and a frame completes in the same cycle, the new word SHALL win: Valid stays 1 and Overrun is 0.
REQ-028 Data_Out, Parity_Err and Frame_Err SHALL hold their values until the next frame completes.
REQ-029 Latency from the stop-bit tick to Valid=1 SHALL be exactly 1 CLK cycle.

Reset
REQ-030 While CLR=0 at a CLK edge, the FSM SHALL go to IDLE and the counter, shift register, registered baud copy, Data_Out, Valid, Parity_Err, Frame_Err, Overrun and Busy SHALL all be 0.
REQ-031 A reset mid-frame SHALL discard the partial frame without raising any flag.
REQ-032 Reception SHALL resume on the first baud tick after CLR returns to 1.

Structure
REQ-033 The shared package SHALL hold the FSM state encodings and the DATA_W default.
REQ-034 The block SHALL use one sub-module, baud_edge_det, which registers CLK_Baud and outputs the one-cycle tick pulse.
REQ-035 The block SHALL be self-contained otherwise and SHALL inter-operate with the team's synchronous transmitter on a shared CLK and CLK_Baud.

Verification
REQ-036 The bench SHALL check a good frame: line 0,1,0,1,0,0,1,0,1,0,1 -> Data_Out=0xA5, Valid=1, Parity_Err=0, Frame_Err=0.
REQ-037 The bench SHALL check a parity error: payload 0x01 with parity bit 0 -> Data_Out=0x01, Parity_Err=1.
REQ-038 The bench SHALL check a framing error: payload 0x3C, correct parity, stop bit 0 -> Frame_Err=1, Valid=1.
REQ-039 The bench SHALL check overrun: frames 0x3C then 0xC3 with no Ack -> Data_Out=0xC3 and Overrun=1; then Ack -> Valid=0 and Overrun=0.
REQ-040 The bench SHALL check Enable gating and mid-frame reset: Enable=0 for 3 ticks mid-frame of 0x81 -> 0x81 still received; CLR=0 after 4 data bits -> all outputs 0, and a following 0x5A frame is received correctly.
